// File: rtl/icache_tag_ctrl.sv
// Instruction-cache miss/refill controller: tag lookup, line-burst refill into the data RAM
// at the tag FIFO write pointer, tag commit or error invalidate, and flush sequencing.
module icache_tag_ctrl #(
    parameter int TAG_W = 20,
    parameter int DP    = 4,
    parameter int BL    = 8,
    localparam int IW   = $clog2(DP),
    localparam int BW   = $clog2(BL),
    localparam int OFS  = BW + 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic [31:0]        cpu_addr,
    output logic               cpu_ack,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_err,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               tag_flush,
    output logic               tag_wr,
    output logic               tag_uwr,
    output logic [IW-1:0]      tag_uptr,
    output logic [TAG_W:0]     tag_wdata,
    input  logic [IW-1:0]      tag_wptr,
    output logic [TAG_W-1:0]   tag_cmp_data,
    input  logic [DP-1:0]      tag_hit,
    input  logic [IW-1:0]      tag_hindex,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_rerr,
    output logic               dram_we,
    output logic [IW+BW-1:0]   dram_addr,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LOOKUP      = 3'd1;
    localparam logic [2:0] S_RESP        = 3'd2;
    localparam logic [2:0] S_REFILL_REQ  = 3'd3;
    localparam logic [2:0] S_REFILL_DATA = 3'd4;
    localparam logic [2:0] S_TAG_COMMIT  = 3'd5;
    localparam logic [2:0] S_ERR_INV     = 3'd6;
    localparam logic [2:0] S_FLUSH       = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [IW-1:0]    line_q, line_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             err_q, err_d;
    logic [31:0]      crit_q, crit_d;
    logic             src_ram_q, src_ram_d;

    logic             hit_s;
    logic             err_nxt_s;
    logic [BW-1:0]    wsel_s;
    logic [TAG_W-1:0] tag_s;
    logic             unused_addr_lsb_s;

    assign hit_s             = |tag_hit;
    assign err_nxt_s         = err_q | mem_rerr;
    assign wsel_s            = addr_q[OFS-1:2];
    assign tag_s             = addr_q[TAG_W+OFS-1:OFS];
    assign unused_addr_lsb_s = ^addr_q[1:0];

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        line_d    = line_q;
        beat_d    = beat_q;
        err_d     = err_q;
        crit_d    = crit_q;
        src_ram_d = src_ram_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (hit_s) begin
                    src_ram_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    src_ram_d = 1'b0;
                    line_d    = tag_wptr;
                    state_d   = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                beat_d = {BW{1'b0}};
                err_d  = 1'b0;
                if (mem_gnt) begin
                    state_d = S_REFILL_DATA;
                end else begin
                    state_d = S_REFILL_REQ;
                end
            end
            S_REFILL_DATA: begin
                if (mem_rvalid) begin
                    beat_d = beat_q + BW'(1);
                    err_d  = err_nxt_s;
                    if (beat_q == wsel_s) begin
                        crit_d = mem_rdata;
                    end else begin
                        crit_d = crit_q;
                    end
                    // The error decision must see the error flag of the last beat itself.
                    if (beat_q == BW'(BL - 1)) begin
                        state_d = err_nxt_s ? S_ERR_INV : S_TAG_COMMIT;
                    end else begin
                        state_d = S_REFILL_DATA;
                    end
                end else begin
                    state_d = S_REFILL_DATA;
                end
            end
            S_TAG_COMMIT: state_d = S_RESP;
            S_ERR_INV:    state_d = S_RESP;
            S_RESP:       state_d = S_IDLE;
            S_FLUSH:      state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            line_q    <= {IW{1'b0}};
            beat_q    <= {BW{1'b0}};
            err_q     <= 1'b0;
            crit_q    <= 32'd0;
            src_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            crit_q    <= crit_d;
            src_ram_q <= src_ram_d;
        end
    end

    // Output decode from the current state; refill writes follow mem_rvalid in the same cycle.
    always_comb begin
        cpu_ack      = 1'b0;
        cpu_rdata    = 32'd0;
        cpu_err      = 1'b0;
        flush_done   = 1'b0;
        tag_flush    = 1'b0;
        tag_wr       = 1'b0;
        tag_uwr      = 1'b0;
        tag_uptr     = {IW{1'b0}};
        tag_wdata    = {(TAG_W+1){1'b0}};
        tag_cmp_data = tag_s;
        mem_req      = 1'b0;
        mem_addr     = {addr_q[31:OFS], {OFS{1'b0}}};
        dram_we      = 1'b0;
        dram_addr    = {(IW+BW){1'b0}};
        dram_wdata   = 32'd0;
        case (state_q)
            S_LOOKUP: begin
                if (hit_s) begin
                    dram_addr = {tag_hindex, wsel_s};
                end else begin
                    dram_addr = {(IW+BW){1'b0}};
                end
            end
            S_REFILL_REQ: mem_req = 1'b1;
            S_REFILL_DATA: begin
                dram_we    = mem_rvalid;
                dram_addr  = {line_q, beat_q};
                dram_wdata = mem_rdata;
            end
            S_TAG_COMMIT: begin
                tag_wr    = 1'b1;
                tag_wdata = {1'b1, tag_s};
            end
            S_ERR_INV: begin
                tag_uwr  = 1'b1;
                tag_uptr = line_q;
            end
            S_RESP: begin
                cpu_ack = 1'b1;
                cpu_err = ~src_ram_q & err_q;
                if (src_ram_q) begin
                    cpu_rdata = dram_rdata;
                end else if (err_q) begin
                    cpu_rdata = 32'd0;
                end else begin
                    cpu_rdata = crit_q;
                end
            end
            S_FLUSH: begin
                tag_flush  = 1'b1;
                flush_done = 1'b1;
            end
            S_IDLE:  cpu_ack = 1'b0;
            default: cpu_ack = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Randomized bench for icache_tag_ctrl: models tag FIFO, data RAM and a burst memory,
// and predicts hit/miss, refill placement and responses from a line-level cache model.
module tb_icache_tag_ctrl;

    localparam int TAG_W = 20;
    localparam int DP    = 4;
    localparam int BL    = 8;
    localparam int IW    = 2;
    localparam int BW    = 3;
    localparam int OFS   = 5;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cpu_req;
    logic [31:0]        cpu_addr;
    logic               cpu_ack;
    logic [31:0]        cpu_rdata;
    logic               cpu_err;
    logic               flush_req;
    logic               flush_done;
    logic               tag_flush;
    logic               tag_wr;
    logic               tag_uwr;
    logic [IW-1:0]      tag_uptr;
    logic [TAG_W:0]     tag_wdata;
    logic [IW-1:0]      tag_wptr;
    logic [TAG_W-1:0]   tag_cmp_data;
    logic [DP-1:0]      tag_hit;
    logic [IW-1:0]      tag_hindex;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    logic               mem_rerr;
    logic               dram_we;
    logic [IW+BW-1:0]   dram_addr;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;

    icache_tag_ctrl #(.TAG_W(TAG_W), .DP(DP), .BL(BL)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .flush_req(flush_req), .flush_done(flush_done),
        .tag_flush(tag_flush), .tag_wr(tag_wr), .tag_uwr(tag_uwr),
        .tag_uptr(tag_uptr), .tag_wdata(tag_wdata), .tag_wptr(tag_wptr),
        .tag_cmp_data(tag_cmp_data), .tag_hit(tag_hit), .tag_hindex(tag_hindex),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
        .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int err_beat = -1;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Environment tag FIFO.
    logic [TAG_W:0]  env_tag [DP];
    logic [IW-1:0]   env_wptr;
    always @(posedge clk) begin
        if (tag_flush) begin
            for (int i = 0; i < DP; i++) env_tag[i] <= '0;
            env_wptr <= '0;
        end else begin
            if (tag_wr) begin
                env_tag[env_wptr] <= tag_wdata;
                env_wptr <= env_wptr + 2'd1;
            end
            if (tag_uwr) env_tag[tag_uptr] <= tag_wdata;
        end
    end
    assign tag_wptr = env_wptr;
    always_comb begin
        tag_hit    = '0;
        tag_hindex = '0;
        for (int i = 0; i < DP; i++) begin
            if (env_tag[i][TAG_W] && env_tag[i][TAG_W-1:0] == tag_cmp_data) begin
                tag_hit[i] = 1'b1;
                tag_hindex = IW'(i);
            end
        end
    end

    // Environment data RAM with one-cycle read.
    logic [31:0] env_ram [DP*BL];
    always @(posedge clk) begin
        if (dram_we) env_ram[dram_addr] <= dram_wdata;
        dram_rdata <= env_ram[dram_addr];
    end

    // Burst memory responder: random grant delay, random beat gaps, junk rvalid when idle.
    initial begin
        int st, cnt, beat;
        logic [31:0] base;
        st = 0; cnt = 0; beat = 0; base = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_rerr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = $urandom;
            if (!reset_n) begin
                st = 0;
            end else if (st == 0) begin
                if (mem_req) begin
                    cnt = $urandom_range(0, 3);
                    if (cnt == 0) begin
                        mem_gnt = 1'b1; base = mem_addr; beat = 0; st = 2;
                    end else begin
                        st = 1;
                    end
                end else if ($urandom_range(0, 4) == 0) begin
                    mem_rvalid = 1'b1; mem_rerr = 1'b1;
                end
            end else if (st == 1) begin
                cnt--;
                if (cnt == 0) begin
                    mem_gnt = 1'b1; base = mem_addr; beat = 0; st = 2;
                end
            end else if ($urandom_range(0, 3) != 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(base + 32'(4 * beat));
                mem_rerr   = (beat == err_beat);
                beat++;
                if (beat == BL) st = 0;
            end
        end
    end

    // Line-level reference model of the cache contents.
    logic [TAG_W-1:0] m_tag [DP];
    bit               m_val [DP];
    int               m_wptr = 0;

    function automatic int m_find(input logic [TAG_W-1:0] t);
        for (int i = 0; i < DP; i++) if (m_val[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    task automatic fetch(input logic [31:0] addr, input int eb, input bit pre);
        logic [TAG_W-1:0] tg;
        logic [31:0] base;
        int hl, line, cyc, nb, nwr, nuwr;
        bit saw_req, done, e;
        tg = addr[TAG_W+OFS-1:OFS];
        base = addr & 32'hFFFF_FFE0;
        hl = m_find(tg);
        line = m_wptr;
        err_beat = (hl < 0) ? eb : -1;
        e = (hl < 0) && (eb >= 0);
        cyc = 0; nb = 0; nwr = 0; nuwr = 0; saw_req = 0; done = 0;
        if (!pre) begin
            @(negedge clk);
            cpu_req = 1'b1;
            cpu_addr = addr;
        end
        while (cyc < 200 && !done) begin
            @(negedge clk);
            cyc++;
            if (hl >= 0 && !pre && cyc == 1)
                check_val("hit_dram_addr", dram_addr, {hl[IW-1:0], addr[OFS-1:2]});
            if (mem_req) begin
                if (!saw_req) check_val("mem_addr", mem_addr, base);
                saw_req = 1;
            end
            if (dram_we) begin
                check_val("dram_waddr", dram_addr, {line[IW-1:0], nb[BW-1:0]});
                check_val("dram_wdata", dram_wdata, mem_word(base + 32'(4 * nb)));
                nb++;
            end
            if (tag_wr || tag_uwr) check_val("wr_uwr_excl", tag_wr & tag_uwr, 0);
            if (tag_wr) begin
                nwr++;
                check_val("tag_wdata", tag_wdata, {1'b1, tg});
            end
            if (tag_uwr) begin
                nuwr++;
                check_val("tag_uptr", tag_uptr, line[IW-1:0]);
                check_val("tag_uwr_wdata", tag_wdata, 0);
            end
            if (cpu_ack) done = 1;
        end
        cpu_req = 1'b0;
        check_val("ack_seen", done, 1);
        if (hl >= 0) begin
            check_val("hit_rdata", cpu_rdata, mem_word(addr));
            check_val("hit_err", cpu_err, 0);
            check_val("hit_no_req", saw_req, 0);
            check_val("hit_no_we", nb, 0);
            if (!pre) check_val("hit_latency", cyc, 2);
        end else begin
            check_val("miss_req", saw_req, 1);
            check_val("miss_beats", nb, BL);
            check_val("miss_tag_wr", nwr, e ? 0 : 1);
            check_val("miss_tag_uwr", nuwr, e ? 1 : 0);
            check_val("miss_err", cpu_err, e);
            check_val("miss_rdata", cpu_rdata, e ? 32'd0 : mem_word(addr));
            if (e) begin
                m_val[line] = 0;
            end else begin
                m_tag[line] = tg;
                m_val[line] = 1;
                m_wptr = (m_wptr + 1) % DP;
            end
        end
    endtask

    task automatic do_flush(input bit with_req, input logic [31:0] addr);
        int cyc;
        bit done;
        cyc = 0; done = 0;
        @(negedge clk);
        flush_req = 1'b1;
        if (with_req) begin
            cpu_req = 1'b1;
            cpu_addr = addr;
        end
        while (cyc < 20 && !done) begin
            @(negedge clk);
            cyc++;
            if (flush_done) begin
                done = 1;
                check_val("flush_tag_flush", tag_flush, 1);
                check_val("flush_no_ack", cpu_ack, 0);
            end
        end
        flush_req = 1'b0;
        check_val("flush_done_seen", done, 1);
        check_val("flush_latency", cyc, 1);
        @(negedge clk);
        check_val("flush_single", {flush_done, tag_flush, cpu_ack}, 0);
        for (int i = 0; i < DP; i++) m_val[i] = 0;
        m_wptr = 0;
    endtask

    task automatic reset_mid(input logic [31:0] addr);
        int cyc;
        bit found;
        cyc = 0; found = 0;
        err_beat = -1;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_addr = addr;
        while (cyc < 200 && !found) begin
            @(negedge clk);
            cyc++;
            if (dram_we && dram_addr[BW-1:0] == 3'd3) found = 1;
        end
        check_val("rst_beat3_seen", found, 1);
        reset_n = 1'b0;
        #1;
        check_val("rst_ctl", {cpu_ack, cpu_err, flush_done, tag_flush, tag_wr, tag_uwr, mem_req, dram_we}, 0);
        check_val("rst_data", {cpu_rdata, dram_wdata}, 0);
        check_val("rst_addr", {tag_uptr, tag_wdata, dram_addr}, 0);
        check_val("rst_cmp", {tag_cmp_data, mem_addr}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fetch(addr, -1, 1);
    endtask

    initial begin
        logic [31:0] a;
        int r, eb;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = 32'd0; flush_req = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_ctl", {cpu_ack, cpu_err, flush_done, tag_flush, tag_wr, tag_uwr, mem_req, dram_we}, 0);
        check_val("reset_data", {cpu_rdata, dram_wdata}, 0);
        check_val("reset_addr", {tag_uptr, tag_wdata, dram_addr}, 0);
        check_val("reset_cmp", {tag_cmp_data, mem_addr}, 0);
        reset_n = 1'b1;

        do_flush(0, 32'd0);
        fetch(32'h0000_1008, -1, 0);
        fetch(32'h0000_101C, -1, 0);

        fetch(32'h0000_2004, 5, 0);
        fetch(32'h0000_2004, -1, 0);

        do_flush(0, 32'd0);
        for (int k = 0; k < 5; k++) fetch(32'h0000_3000 + 32'(k * 32'h20), -1, 0);
        fetch(32'h0000_3000, -1, 0);

        do_flush(1, 32'h0000_4008);
        fetch(32'h0000_4008, -1, 1);

        reset_mid(32'h0000_5010);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 15);
            a = 32'hA000_8000 + 32'($urandom_range(0, 5)) * 32'h0001_0000 + 32'($urandom_range(0, 7)) * 32'd4;
            if (r == 0) begin
                do_flush(0, 32'd0);
            end else if (r == 1) begin
                do_flush(1, a);
                fetch(a, -1, 1);
            end else begin
                eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
                fetch(a, eb, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
